// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - MEM-stage 32-bit load/store over a 16-bit external SRAM
// Each access runs as two half-word phases (LO then HI) and stalls the pipeline via ready.
module mem_stage_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] store_val,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_w_q, op_w_d;
  logic [16:0] offset_q, offset_d;
  logic [31:0] store_val_q, store_val_d;
  logic [31:0] read_data_q, read_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_w_q      <= 1'b0;
      offset_q    <= 17'd0;
      store_val_q <= 32'd0;
      read_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_w_q      <= op_w_d;
      offset_q    <= offset_d;
      store_val_q <= store_val_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_w_d      = op_w_q;
    offset_d    = offset_q;
    store_val_d = store_val_q;
    read_data_d = read_data_q;
    ready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = !(mem_r_en || mem_w_en);
        if (mem_r_en || mem_w_en) begin
          // A store wins when both enables are set.
          op_w_d      = mem_w_en;
          offset_d    = 17'((address - BASE_ADDR) >> 2);
          store_val_d = store_val;
          cnt_d       = 4'd0;
          state_d     = S_LO;
        end
      end
      S_LO: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 4'd0;
          state_d = S_HI;
          if (!op_w_q) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HI: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
          if (!op_w_q) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pad signals depend only on registered state, never on the request inputs.
  always_comb begin
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (state_q == S_LO || state_q == S_HI) begin
      sram_addr = {offset_q, state_q == S_HI};
      if (op_w_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == S_HI) ? store_val_q[31:16] : store_val_q[15:0];
        // WE rises in the last cycle so address/data stay stable across the edge.
        sram_we_n   = (cnt_q == LAST_CNT);
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - directed bench for mem_stage_sram with an SRAM model and load scoreboard
module tb_mem_stage_sram;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, store_val;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n, sram_oe_n;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load;
  logic        mem_init;
  logic [15:0] mem [64];

  mem_stage_sram #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .store_val(store_val), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (!sram_we_n) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; runs cycles 0..2W+1 of one access.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] val, input logic [31:0] exp_rd);
    logic [16:0] off;
    logic        hi;
    int          ph;
    off = 17'((addr - 32'd1024) >> 2);
    mem_r_en = rd; mem_w_en = wr; address = addr; store_val = val;
    if (!wr) exp_q.push_back(exp_rd);
    for (int c = 0; c <= 2 * W + 1; c++) begin
      @(negedge clk);
      chk($sformatf("ready_c%0d", c), {31'd0, ready}, {31'd0, c == 2 * W + 1});
      if (c >= 1 && c <= 2 * W) begin
        hi = (c > W);
        ph = (c - 1) % W;
        chk($sformatf("addr_c%0d", c), {14'd0, sram_addr}, {14'd0, off, hi});
        if (wr) begin
          chk($sformatf("we_n_c%0d", c), {31'd0, sram_we_n}, {31'd0, ph == W - 1});
          chk($sformatf("dq_oe_c%0d", c), {31'd0, sram_dq_oe}, 32'd1);
          chk($sformatf("dq_out_c%0d", c), {16'd0, sram_dq_out}, {16'd0, hi ? val[31:16] : val[15:0]});
          chk($sformatf("oe_n_st_c%0d", c), {31'd0, sram_oe_n}, 32'd1);
        end else begin
          chk($sformatf("oe_n_ld_c%0d", c), {31'd0, sram_oe_n}, 32'd0);
          chk($sformatf("dq_oe_ld_c%0d", c), {31'd0, sram_dq_oe}, 32'd0);
          chk($sformatf("we_n_ld_c%0d", c), {31'd0, sram_we_n}, 32'd1);
        end
      end
      if (c == 2 * W + 1) begin
        if (!wr) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            last_load = exp_q.pop_front();
            chk("read_data", read_data, last_load);
          end
        end else begin
          chk("read_data_after_store", read_data, last_load);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1; last_load = 32'd0;
    mem_r_en = 1'b0; mem_w_en = 1'b0; address = 32'd0; store_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0);
    idle(); @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF);
    idle(); @(posedge clk); #1;

    // Back-to-back loads: request stays high through the IDLE cycle between them.
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'hA001A000);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hA003A002);
    idle(); @(posedge clk); #1;

    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'd0);
    idle(); @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678);
    idle(); @(posedge clk); #1;

    // Reset during the first HI cycle of a store.
    mem_w_en = 1'b1; address = 32'd1040; store_val = 32'hCAFEF00D;
    repeat (W + 1) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_hi_addr", {14'd0, sram_addr}, 32'd9);
    chk("mid_hi_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1; idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("abort_read_data", read_data, 32'd0);
    @(posedge clk); #1;
    last_load = 32'd0;
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF);
    idle(); @(posedge clk); #1;

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- MEM-stage memory access unit, directly downstream of the execute stage.
- Takes the ALU result as a byte address plus the store value, and performs a 32-bit load or store on the board's external 16-bit SRAM as two 16-bit half-word transactions.
- Holds `ready` low while busy; the hazard/pipeline-control logic uses this to freeze all pipeline registers until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: cycles per half-word transaction. Legal range 2..15.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- address  in  32  byte address (execute-stage ALU result).
- store_val  in  32  store data (forwarded val2).
- read_data  out  32  loaded word.
- ready  out  1  high = stage not stalling pipeline.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  write data to SRAM pad.
- sram_dq_oe  out  1  pad output enable; the top level builds the tristate.
- sram_dq_in  in  16  read data from SRAM pad.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- States: IDLE, LO, HI, DONE. Wait counter cnt is 4 bits.
- Reset (rst=1 at an edge) gives:
  - state=IDLE, cnt=0, read_data=0;
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0;
  - sram_we_n=1, sram_oe_n=1.
- Reset mid-access:
  - aborts the access; a half-written word is acceptable;
  - the SRAM strobes go inactive on the very next cycle.
- IDLE:
  - No request: ready=1.
  - Request present: ready=0 combinationally in the same cycle. Latch op, word offset and store_val; go to LO with cnt=0.
  - Both enables high: treat as a store.
- Word offset = (address − BASE_ADDR)[18:2], 17 bits. Subtraction is modulo 2^32, so out-of-range addresses wrap silently.
- sram_addr = {offset, 0} in LO and {offset, 1} in HI. The low half-word holds bits 15:0.
- LO and HI each last exactly WAIT_CYCLES cycles; cnt counts 0..WAIT_CYCLES−1, then clears.
- Store:
  - sram_dq_oe=1 throughout each half.
  - sram_dq_out = store_val[15:0] in LO, [31:16] in HI.
  - sram_we_n=0 for cnt < WAIT_CYCLES−1 and 1 in the last cycle, so address and data are held while WE rises between halves.
  - sram_oe_n=1 throughout.
- Load:
  - sram_oe_n=0 and sram_dq_oe=0 throughout.
  - In the last cycle of LO, sample sram_dq_in into read_data[15:0]; in the last cycle of HI, into read_data[31:16].
  - read_data holds until the next load's samples; stores never modify it.
- HI end → DONE. DONE: ready=1 for exactly one cycle, then IDLE.
  - The pipeline advances on that edge.
  - A request still present in IDLE afterwards is a new instruction.
- Latency: with cycle 0 being the IDLE cycle that sees the request:
  - LO occupies cycles 1..W, HI occupies W+1..2W, DONE is cycle 2W+1.
  - Stall = 2W+1 cycles; 5 at the default W=2.
  - read_data is valid from cycle 2W+1.
- Outputs other than ready are driven only from registered state and latched values. No combinational path from request inputs to SRAM pins.
- Inputs changing during LO/HI are ignored, since values were latched in IDLE.

Test Plan:
- Reset → ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- Store:
  - Stimulus: mem_w_en=1, address=1032, store_val=0xDEADBEEF, W=2.
  - Required: ready=0 for cycles 0–4 and 1 at cycle 5.
  - Required: sram_addr=4 with dq 0xBEEF, then sram_addr=5 with dq 0xDEAD.
  - Required: we_n pattern 0,1,0,1.
- Load same address with an SRAM model → read_data=0xDEADBEEF at cycle 5, ready=1 that cycle, oe_n=0 during access.
- Back-to-back loads, addresses 1024 then 1028 → each stalls 5 cycles; one IDLE cycle between them with ready=0; read_data correct for each.
- Both enables, address=1024, store_val=0x12345678 → a store occurs; read_data unchanged.
- rst=1 during HI of a store → next cycle state=IDLE, we_n=1, dq_oe=0; a subsequent load completes normally.
